// File: rtl/div_iter_pkg.sv
// Shared codes for the iterative divider: FSM states, handshake levels, constants.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  // Magnitude of a possibly-signed word; abs(0x80000000) stays 0x80000000 as unsigned.
  function automatic logic [31:0] abs32(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for EX DIV/DIVU.
// Returns {remainder, quotient}; outputs are registered and valid only in END.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state, state_nx;
  logic [4:0]  cnt;
  logic [64:0] rem_dvd;
  logic [31:0] divisor;
  logic        neg_q, neg_r;
  logic [63:0] result_q;
  logic        ready_q;

  logic [64:0] shifted, step;
  logic [32:0] diff;
  logic [63:0] fixed;

  // One restoring step: shift, trial-subtract from the upper 33 bits, keep or restore.
  always_comb begin
    shifted = {rem_dvd[63:0], 1'b0};
    diff    = shifted[64:32] - {1'b0, divisor};
    step    = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};
    fixed   = {neg_r ? (~step[63:32] + 32'd1) : step[63:32],
               neg_q ? (~step[31:0]  + 32'd1) : step[31:0]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      DivFree:   if (start_i == DivStart && !annul_i)
                   state_nx = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      DivByZero: state_nx = DivEnd;
      DivOn:     if (cnt == 5'd31) state_nx = DivEnd;
      DivEnd:    if (start_i == DivStop) state_nx = DivFree;
      default:   state_nx = DivFree;
    endcase
    if (annul_i && state != DivFree) state_nx = DivFree;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= 5'd0;
      rem_dvd  <= 65'd0;
      divisor  <= ZeroWord;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= DivResultNotReady;
    end else begin
      state <= state_nx;
      case (state)
        DivFree: if (state_nx == DivOn) begin
          rem_dvd <= {33'd0, abs32(signed_div_i, opdata1_i)};
          divisor <= abs32(signed_div_i, opdata2_i);
          neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_r   <= signed_div_i & opdata1_i[31];
          cnt     <= 5'd0;
        end
        DivOn: if (!annul_i) begin
          rem_dvd <= step;
          cnt     <= cnt + 5'd1;
        end
        default: ;
      endcase
      ready_q <= (state_nx == DivEnd) ? DivResultReady : DivResultNotReady;
      // Result is captured on entry to END and held; BYZERO enters with zero.
      if (state_nx != DivEnd)
        result_q <= 64'd0;
      else if (state == DivOn)
        result_q <= fixed;
      else if (state == DivByZero)
        result_q <= 64'd0;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results queued at start, popped at ready.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div_iter dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, wait for ready, check latency and result, release.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble);
    int cyc;
    logic [63:0] exp;
    sb_q.push_back(model(sgn, a, b));
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (scramble && cyc == 2) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
      end
    end while (!ready_o && cyc < 80);
    chk($sformatf("latency %h/%h", a, b), 64'(cyc), (b == 0) ? 64'd2 : 64'd33);
    if (sb_q.size() == 0) chk("scoreboard empty", 64'd0, 64'd1);
    else begin
      exp = sb_q.pop_front();
      chk($sformatf("result %s %h/%h", sgn ? "DIV" : "DIVU", a, b), result_o, exp);
    end
    tick();
    chk("ready held in END", {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    tick();
    chk("ready clear after drop", {63'd0, ready_o}, 64'd0);
    chk("result clear after drop", result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    tick(); tick();
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_div(1'b0, 32'd12345, 32'd0, 1'b0);
    run_div(1'b1, 32'h80000000, 32'd0, 1'b0);
    run_div(1'b1, 32'h80000000, 32'h80000000, 1'b0);
    run_div(1'b0, 32'd3, 32'hFFFFFFFF, 1'b0);

    // Annul at iteration 10; no result is expected for the aborted op.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ready low after annul", {63'd0, ready_o}, 64'd0);
      tick();
    end
    run_div(1'b0, 32'd50, 32'd5, 1'b0);

    // Reset mid-ON.
    signed_div_i = 1'b1; opdata1_i = 32'hDEAD0000; opdata2_i = 32'd77; start_i = 1'b1;
    repeat (6) tick();
    rst = 1'b1; start_i = 1'b0;
    tick();
    chk("rst mid-ON ready", {63'd0, ready_o}, 64'd0);
    chk("rst mid-ON result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // Reset during END.
    signed_div_i = 1'b0; opdata1_i = 32'd99; opdata2_i = 32'd10; start_i = 1'b1;
    repeat (33) tick();
    chk("END before rst result", result_o, model(1'b0, 32'd99, 32'd10));
    rst = 1'b1;
    tick();
    chk("rst in END ready", {63'd0, ready_o}, 64'd0);
    chk("rst in END result", result_o, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    tick();

    // Operand changes during ON must not matter.
    run_div(1'b0, 32'd100, 32'd7, 1'b1);
    run_div(1'b1, 32'hFFFF0001, 32'd13, 1'b1);

    for (int i = 0; i < 6; i++)
      run_div(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 32'hFFFF), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
